// File: rtl/add_serial_pkg.sv
// Shared types and constants for the bit-serial adder operand sequencer.
package add_serial_pkg;

  localparam int WIDTH      = 8;
  localparam int ADD_CYCLES = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPT,
    S_REL
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

endpackage

// File: rtl/add_serial_opq.sv
// Synchronous operand-pair FIFO; storage is not reset, only pointers and count.
module add_serial_opq
  import add_serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  pair_t din,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output pair_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  pair_t         mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/add_serial_seq.sv
// Operand sequencer for the 8-bit bit-serial adder: queues pairs, drives en/a/b,
// captures the sum. Optional self-check output err under ADD_SERIAL_SEQ_CHECK_EN.
module add_serial_seq #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             busy
`ifdef ADD_SERIAL_SEQ_CHECK_EN
  ,
  output logic             err
`endif
);

  import add_serial_pkg::*;

  localparam int CNT_W = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             capture;
  logic             q_full, q_empty, q_pop;
  pair_t            q_head, q_din;

  assign q_din.a = in_a;
  assign q_din.b = in_b;

  add_serial_opq #(
    .DEPTH (FIFO_DEPTH)
  ) u_opq (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && !q_full),
    .din   (q_din),
    .pop   (q_pop),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    add_en      = 1'b0;
    q_pop       = 1'b0;
    capture     = 1'b0;

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!q_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Operands reach the adder pins in the same cycle en is raised.
        add_en  = 1'b1;
        add_a_d = q_head.a;
        add_b_d = q_head.b;
        q_pop   = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ADD_CYCLES - 1)) state_d = S_CAPT;
      end
      S_CAPT: begin
        // Adder sits in DONE while en stays low, so stalling here is safe.
        if (!res_valid_q || res_ready) begin
          capture     = 1'b1;
          res_sum_d   = add_out;
          res_valid_d = 1'b1;
          state_d     = S_REL;
        end
      end
      S_REL: begin
        add_en  = 1'b1;
        state_d = q_empty ? S_IDLE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = !q_full;
  assign add_a     = add_a_d;
  assign add_b     = add_b_d;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign busy      = (state_q != S_IDLE) || !q_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
    end
  end

`ifdef ADD_SERIAL_SEQ_CHECK_EN
  // The held add_a/add_b registers are the copy of the issued pair.
  logic             err_q, err_d;
  logic [WIDTH-1:0] ref_sum;

  always_comb begin
    ref_sum = add_a_q + add_b_q;
    err_d   = err_q;
    if (capture && (add_out != ref_sum)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_add_serial_seq.sv
// Directed self-checking bench for add_serial_seq with a behavioural serial adder.
module tb_add_serial_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       add_en;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_out;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_sum;
  logic       busy;
`ifdef ADD_SERIAL_SEQ_CHECK_EN
  logic       err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  add_serial_seq #(
    .WIDTH      (8),
    .FIFO_DEPTH (4),
    .ADD_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .busy      (busy)
`ifdef ADD_SERIAL_SEQ_CHECK_EN
    ,
    .err       (err)
`endif
  );

  // Behavioural adder: IDLE -en-> ADD (8 cycles) -> DONE -en-> IDLE.
  logic [1:0] mst = 2'd0;
  logic [2:0] mcnt = 3'd0;
  logic [7:0] msum = 8'h00;
  logic       force_zero = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mst  <= 2'd0;
      mcnt <= 3'd0;
    end else begin
      case (mst)
        2'd0: if (add_en) begin
          msum <= add_a + add_b;
          mcnt <= 3'd0;
          mst  <= 2'd1;
        end
        2'd1: begin
          if (mcnt == 3'd7) mst <= 2'd2;
          else              mcnt <= mcnt + 3'd1;
        end
        2'd2: if (add_en) mst <= 2'd0;
        default: mst <= 2'd0;
      endcase
    end
  end

  assign add_out = force_zero ? 8'h00 : ((mst == 2'd2) ? msum : 8'hA5);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int w;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    w        = 0;
    while (!in_ready && w < 50) begin
      tick;
      w++;
    end
    chk("push_ready", {31'd0, in_ready}, 32'd1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input logic [7:0] exp, input int lat);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (!res_valid && n < 40);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_sum"}, {24'd0, res_sum}, {24'd0, exp});
  endtask

  logic [7:0] pa [5];
  logic [7:0] pb [5];
  logic [7:0] ps [5];
  int         e;
  int         nres;

  initial begin
    // Reset state
    tick;
    tick;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_add_en", {31'd0, add_en}, 32'd0);
    chk("rst_add_a", {24'd0, add_a}, 32'd0);
    chk("rst_add_b", {24'd0, add_b}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_sum", {24'd0, res_sum}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef ADD_SERIAL_SEQ_CHECK_EN
    chk("rst_err", {31'd0, err}, 32'd0);
`endif
    rst = 1'b0;
    tick;

    // 0x05 + 0x03: en only in LOAD (after edge 1) and REL (after edge 11)
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'h05;
    in_b      = 8'h03;
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      chk($sformatf("t1_en_%0d", k), {31'd0, add_en}, {31'd0, (k == 1 || k == 11)});
      if (k == 1) begin
        chk("t1_add_a", {24'd0, add_a}, 32'h05);
        chk("t1_add_b", {24'd0, add_b}, 32'h03);
      end
      if (k == 5) begin
        chk("t1_hold_a", {24'd0, add_a}, 32'h05);
        chk("t1_busy", {31'd0, busy}, 32'd1);
      end
      if (k == 10) chk("t1_vld_early", {31'd0, res_valid}, 32'd0);
      if (k == 11) begin
        chk("t1_vld", {31'd0, res_valid}, 32'd1);
        chk("t1_sum", {24'd0, res_sum}, 32'h08);
      end
      if (k == 12) begin
        chk("t1_vld_clr", {31'd0, res_valid}, 32'd0);
        chk("t1_idle", {31'd0, busy}, 32'd0);
      end
    end

    // 0xFF + 0x01 wraps to 0x00
    push(8'hFF, 8'h01);
    wait_res("t2", 8'h00, 11);
    chk("t2_vld", {31'd0, res_valid}, 32'd1);
`ifdef ADD_SERIAL_SEQ_CHECK_EN
    chk("t2_err", {31'd0, err}, 32'd0);
`endif
    tick;
    tick;

    // Five pairs back-to-back; queue fills after the fifth push
    pa[0] = 8'h01; pb[0] = 8'h02; ps[0] = 8'h03;
    pa[1] = 8'h10; pb[1] = 8'h22; ps[1] = 8'h32;
    pa[2] = 8'h80; pb[2] = 8'h80; ps[2] = 8'h00;
    pa[3] = 8'h7F; pb[3] = 8'h01; ps[3] = 8'h80;
    pa[4] = 8'hAA; pb[4] = 8'h55; ps[4] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      tick;
      chk($sformatf("t3_ready_%0d", i), {31'd0, in_ready}, {31'd0, (i < 4)});
    end
    in_valid = 1'b0;
    e    = 4;
    nres = 0;
    while (e < 70) begin
      tick;
      e++;
      if (res_valid) begin
        if (nres < 5) begin
          chk($sformatf("t3_sum_%0d", nres), {24'd0, res_sum}, {24'd0, ps[nres]});
          chk($sformatf("t3_edge_%0d", nres), e, 11 * (nres + 1));
        end
        nres++;
      end
    end
    chk("t3_count", nres, 5);
    chk("t3_idle", {31'd0, busy}, 32'd0);

    // Back-pressure: second op stalls in CAPT
    res_ready = 1'b0;
    push(8'h11, 8'h22);
    push(8'h40, 8'h05);
    e = 1;
    while (e < 11) begin
      tick;
      e++;
    end
    chk("t4_vld1", {31'd0, res_valid}, 32'd1);
    chk("t4_sum1", {24'd0, res_sum}, 32'h33);
    while (e < 30) begin
      tick;
      e++;
    end
    chk("t4_stall_vld", {31'd0, res_valid}, 32'd1);
    chk("t4_stall_sum", {24'd0, res_sum}, 32'h33);
    chk("t4_stall_en", {31'd0, add_en}, 32'd0);
    chk("t4_stall_busy", {31'd0, busy}, 32'd1);
    res_ready = 1'b1;
    tick;
    chk("t4_vld2", {31'd0, res_valid}, 32'd1);
    chk("t4_sum2", {24'd0, res_sum}, 32'h45);
    tick;
    chk("t4_vld_clr", {31'd0, res_valid}, 32'd0);
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // Reset while waiting with three pairs still queued
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a     = 8'(i + 1);
      in_b     = 8'h01;
      tick;
    end
    in_valid = 1'b0;
    chk("t5_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick;
    chk("t5_vld", {31'd0, res_valid}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_en", {31'd0, add_en}, 32'd0);
    rst = 1'b0;
    tick;
    push(8'h10, 8'h20);
    wait_res("t5", 8'h30, 11);
    tick;
    tick;

`ifdef ADD_SERIAL_SEQ_CHECK_EN
    // Corrupted adder output raises sticky err
    force_zero = 1'b1;
    push(8'h01, 8'h01);
    wait_res("t6", 8'h00, 11);
    chk("t6_err", {31'd0, err}, 32'd1);
    force_zero = 1'b0;
    tick;
    tick;
    tick;
    chk("t6_err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1;
    tick;
    chk("t6_err_rst", {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
